mem_port_arbiter: RTL

Shared 16x8 program/data memory with a two-requester arbiter. It sits between the basic-computer control FSM (CPU port) and the host loader/debug port (HOST port), and serialises their accesses onto one single-port array. Each access is a req/ack transaction with a fixed three-cycle service time. Grant policy is round-robin or fixed-priority, selected at compile time.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU and HOST request/ack ports, plus the busy/owner status,
// shared between the arbiter (slave) and the requesters (master).
interface mem_port_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;

    logic          busy;
    logic          grant_host;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output busy, grant_host
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  busy, grant_host
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port 2^AW x DW memory shared by CPU and HOST through a 3-cycle req/ack FSM.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise HOST has fixed priority.
module mem_port_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    state_t        state_next;
    logic          owner_host;
    logic          win_host;
    logic          any_req;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] host_rdata_q;
    logic [DW-1:0] access_data;
    logic [DW-1:0] mem [2**AW];

    assign any_req = bus.cpu_req | bus.host_req;

    always_comb begin
        state_next = state;
        win_host   = bus.host_req;
        if (bus.cpu_req && bus.host_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_host = ~owner_host;
`else
            win_host = 1'b1;
`endif
        end
        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Owner starts as HOST so the first round-robin tie goes to the CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner_host <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                owner_host <= win_host;
                we_q       <= win_host ? bus.host_we    : bus.cpu_we;
                addr_q     <= win_host ? bus.host_addr  : bus.cpu_addr;
                wdata_q    <= win_host ? bus.host_wdata : bus.cpu_wdata;
            end
        end
    end

    // A write echoes its own data back as the winner's read result.
    assign access_data = we_q ? wdata_q : mem[addr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else if (state == ACCESS) begin
            if (owner_host) host_rdata_q <= access_data;
            else            cpu_rdata_q  <= access_data;
        end
    end

    // Array contents survive reset; the write commits only on the ACCESS edge.
    always_ff @(posedge clk) begin
        if (state == ACCESS && we_q) mem[addr_q] <= wdata_q;
    end

    assign bus.cpu_ack    = (state == RESP) && !owner_host;
    assign bus.host_ack   = (state == RESP) &&  owner_host;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.host_rdata = host_rdata_q;
    assign bus.busy       = (state != IDLE);
    assign bus.grant_host = owner_host;
endmodule
